// File: rtl/ssd_scan_driver.sv
// Purpose: 4-digit seven-segment scan driver with sequential binary-to-BCD conversion.
// Latency: 15 clocks per conversion (1 sample, 13 shift, 1 commit); display decode is combinational.
// Backpressure: none; conversion free-runs and re-samples `value` every 15 clocks.
//
// Ports:
//   clk       - system clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   value     - 13-bit unsigned number to display (0..8191)
//   Anode     - active-low digit enables, [3]=thousands .. [0]=units
//   LED_out   - active-low segments {a,b,c,d,e,f,g} on [6:0]
//   busy      - high while a conversion is in SHIFT or DONE
//   conv_done - one-cycle pulse in the cycle the displayed digits change
module ssd_scan_driver #(
  parameter int REFRESH_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [3:0]  Anode,
  output logic [6:0]  LED_out,
  output logic        busy,
  output logic        conv_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [12:0]             r_bin;
  logic [15:0]             r_bcd;
  logic [3:0]              r_cnt;
  logic [15:0]             r_digits;
  logic [REFRESH_BITS-1:0] r_refresh;
  logic                    r_conv_done;

  logic [15:0]             w_bcd_adj;
  logic [1:0]              w_sel;
  logic [3:0]              w_nib;
  logic                    w_blank;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: 13 shifts (count 0..12) then commit
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = SHIFT;
      SHIFT:   w_next = (r_cnt == 4'd12) ? DONE : SHIFT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble >= 5 before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_digits    <= '0;
      r_conv_done <= 1'b0;
    end else begin
      r_conv_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_bin <= value;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 4'd1;
        end
        DONE: begin
          r_digits    <= r_bcd;
          r_conv_done <= 1'b1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Free-running refresh counter; top two bits pick the digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];

  // Digit select and leading-zero blanking (registered state only)
  always_comb begin
    Anode   = 4'b1111;
    w_nib   = 4'd0;
    w_blank = 1'b0;
    case (w_sel)
      2'd0: begin
        Anode   = 4'b0111;
        w_nib   = r_digits[15:12];
        w_blank = (r_digits[15:12] == 4'd0);
      end
      2'd1: begin
        Anode   = 4'b1011;
        w_nib   = r_digits[11:8];
        w_blank = (r_digits[15:8] == 8'd0);
      end
      2'd2: begin
        Anode   = 4'b1101;
        w_nib   = r_digits[7:4];
        w_blank = (r_digits[15:4] == 12'd0);
      end
      default: begin
        Anode   = 4'b1110;
        w_nib   = r_digits[3:0];
        w_blank = 1'b0;
      end
    endcase
  end

  // Active-low segment decode; non-decimal nibbles go dark
  always_comb begin
    LED_out = 7'b1111111;
    if (!w_blank) begin
      case (w_nib)
        4'd0:    LED_out = 7'b0000001;
        4'd1:    LED_out = 7'b1001111;
        4'd2:    LED_out = 7'b0010010;
        4'd3:    LED_out = 7'b0000110;
        4'd4:    LED_out = 7'b1001100;
        4'd5:    LED_out = 7'b0100100;
        4'd6:    LED_out = 7'b0100000;
        4'd7:    LED_out = 7'b0001111;
        4'd8:    LED_out = 7'b0000000;
        4'd9:    LED_out = 7'b0000100;
        default: LED_out = 7'b1111111;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign conv_done = r_conv_done;

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;
  localparam int RB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] value = 13'd0;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;
  logic        busy;
  logic        conv_done;

  int checks = 0;
  int errors = 0;

  ssd_scan_driver #(.REFRESH_BITS(RB)) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .Anode     (Anode),
    .LED_out   (LED_out),
    .busy      (busy),
    .conv_done (conv_done)
  );

  always #5 clk = ~clk;

  // Reference model: edges since reset, sampled value, value on display
  int m_n     = 0;
  int m_samp  = 0;
  int m_shown = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_n     = 0;
      m_shown = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_n = m_n + 1;
      if ((m_n - 1) % 15 == 0)  m_samp  = value;
      if ((m_n - 1) % 15 == 14) m_shown = m_samp;
    end
  end

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_led(input int v, input int s);
    case (s)
      0: return (v < 1000) ? 7'b1111111 : seg7(v / 1000);
      1: return (v < 100)  ? 7'b1111111 : seg7((v / 100) % 10);
      2: return (v < 10)   ? 7'b1111111 : seg7((v / 10) % 10);
      default: return seg7(v % 10);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      int s;
      s = (m_n % (1 << RB)) >> (RB - 2);
      chk("anode", Anode, 4'hF ^ (4'h8 >> s));
      chk("led", LED_out, exp_led(m_shown, s));
      chk("busy", busy, (m_n > 0) && ((m_n - 1) % 15 != 14));
      chk("conv_done", conv_done, (m_n > 0) && ((m_n - 1) % 15 == 14));
    end
  end

  logic [6:0] leds [4];

  task automatic wait_done(input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!conv_done && k < limit);
    chk("conv_done_seen", conv_done, 1);
  endtask

  // Called in the conv_done cycle; 15 consecutive cycles cover every digit
  task automatic collect();
    for (int s = 0; s < 4; s++) leds[s] = 7'bx;
    for (int i = 0; i < 15; i++) begin
      case (Anode)
        4'b0111: leds[0] = LED_out;
        4'b1011: leds[1] = LED_out;
        4'b1101: leds[2] = LED_out;
        4'b1110: leds[3] = LED_out;
        default: ;
      endcase
      if (i < 14) @(negedge clk);
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
    chk({tag, "_thousands"}, leds[0], e0);
    chk({tag, "_hundreds"},  leds[1], e1);
    chk({tag, "_tens"},      leds[2], e2);
    chk({tag, "_units"},     leds[3], e3);
  endtask

  task automatic show(input int v, input string tag, input logic [6:0] e0, input logic [6:0] e1,
                      input logic [6:0] e2, input logic [6:0] e3);
    int k;
    value = v[12:0];
    wait_done(40, k);
    wait_done(40, k);
    collect();
    check_digits(tag, e0, e1, e2, e3);
  endtask

  initial begin
    int k;
    logic [3:0] prev;
    bit wrapped;

    // Reset for two edges, release with value=0
    rst = 1'b1;
    value = 13'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_anode", Anode, 4'b0111);
    chk("reset_led", LED_out, 7'b1111111);
    chk("reset_busy", busy, 0);
    wait_done(40, k);
    chk("first_done_latency", k, 15);
    collect();
    check_digits("zero", 7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001);

    show(1234, "v1234", 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100);
    show(8191, "v8191", 7'b0000000, 7'b1001111, 7'b0000100, 7'b1001111);
    show(7,    "v7",    7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111);
    show(1000, "v1000", 7'b1001111, 7'b0000001, 7'b0000001, 7'b0000001);

    // Value changes on the 3rd SHIFT cycle of the 42 conversion
    value = 13'd42;
    wait_done(40, k);
    repeat (3) @(negedge clk);
    value = 13'd99;
    wait_done(40, k);
    collect();
    check_digits("v42", 7'b1111111, 7'b1111111, 7'b1001100, 7'b0010010);
    wait_done(40, k);
    collect();
    check_digits("v99", 7'b1111111, 7'b1111111, 7'b0000100, 7'b0000100);

    // One-cycle reset on the 6th SHIFT cycle of the 555 conversion
    value = 13'd555;
    wait_done(40, k);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_done(40, k);
    chk("post_reset_latency", k, 15);
    collect();
    check_digits("v555", 7'b1111111, 7'b0100100, 7'b0100100, 7'b0100100);

    // Refresh wrap: units select must be followed by thousands select
    wrapped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prev = Anode;
      @(negedge clk);
      if (prev == 4'b1110 && Anode != 4'b1110) begin
        chk("wrap_anode", Anode, 4'b0111);
        wrapped = 1'b1;
      end
    end
    chk("wrap_seen", wrapped, 1);

    // Randomized values, change times and occasional resets
    repeat (60) begin
      value = 13'($urandom_range(0, 8191));
      repeat ($urandom_range(1, 25)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ssd_scan_driver.md
SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_BITS, default 20, giving the width of the refresh counter; it SHALL be at least 3.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port value, input, 13 bits: the unsigned number to display, range 0..8191, produced by the processor top-level SSD selection mux.
REQ-005 The block SHALL have port Anode, output, 4 bits: active-low digit enables, where bit 3 is the thousands digit and bit 0 is the units digit.
REQ-006 The block SHALL have port LED_out, output, 7 bits: active-low segments, mapped {a,b,c,d,e,f,g} onto bits [6:0].
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port conv_done, output, 1 bit: a one-cycle pulse when the displayed digits update.

Function
REQ-009 Binary-to-BCD conversion SHALL be a sequential shift-and-add-3 FSM with states IDLE, SHIFT and DONE.
REQ-010 In IDLE the FSM SHALL capture value into a 13-bit shift register, clear the 16-bit BCD accumulator, clear the shift count, and go to SHIFT.
REQ-011 In SHIFT, each cycle SHALL:
  - add 3 to every BCD nibble that is at least 5;
  - then shift {BCD, binary} left by 1;
  - increment the shift count.
  After the 13th shift the FSM SHALL go to DONE.
REQ-012 In DONE the FSM SHALL copy the BCD accumulator into the digit register (4 nibbles), assert conv_done for that cycle only, and return to IDLE.
REQ-013 A full cycle SHALL take 15 clocks: 1 IDLE, 13 SHIFT, 1 DONE; the digit register SHALL reflect the value sampled in IDLE at the DONE edge 14 clocks later.
REQ-014 Conversion SHALL be continuous: a new sample SHALL be taken every 15 clocks whether or not value changed.
REQ-015 Changes to value during SHIFT or DONE SHALL be ignored until the next IDLE sample.
REQ-016 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-017 A free-running REFRESH_BITS-bit counter SHALL increment every cycle and wrap from all-ones to 0; its top two bits SHALL form the digit select sel.
REQ-018 Anode SHALL be 4'b0111 for sel=0 (thousands), 4'b1011 for sel=1 (hundreds), 4'b1101 for sel=2 (tens) and 4'b1110 for sel=3 (units).
REQ-019 LED_out SHALL show the digit selected by sel using this active-low decode:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100;
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-020 Leading zeros SHALL be blanked:
  - the thousands digit is blanked if it is 0;
  - hundreds is blanked if thousands and hundreds are both 0;
  - tens is blanked if thousands, hundreds and tens are all 0;
  - units is never blanked.
  A blanked digit SHALL drive LED_out=7'b1111111 while its Anode stays active.
REQ-021 Anode and LED_out SHALL be combinational decodes of registered state only (sel and the digit register), with no combinational path from value.
REQ-022 Digit nibbles SHALL never exceed 9, because the maximum input 8191 fits in 4 BCD digits; the decode of nibbles 10..15 SHALL be 7'b1111111.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL enter IDLE, clear the shift count, shift register, BCD accumulator, digit register and refresh counter, and set conv_done=0.
REQ-024 The outputs after reset SHALL be Anode=4'b0111, LED_out=7'b1111111 (thousands zero blanked) and busy=0.
REQ-025 A reset during SHIFT SHALL abort the conversion with no conv_done pulse, leave the digit register at 0, and restart sampling on the first cycle after rst falls.

Verification (REFRESH_BITS=4)
REQ-026 Reset check: rst=1 for 2 cycles, then release with value=0.
  Response: Anode=0111, LED_out=1111111, busy=0; conv_done pulses 15 cycles after release; the units digit then shows 0000001.
REQ-027 Conversion and scan: value=1234 held.
  Response: after conv_done, stepping sel 0..3 gives Anode 0111/1011/1101/1110 with LED_out 1001111/0010010/0000110/1001100.
REQ-028 Boundary values: value=8191 shows 8,1,9,1; value=7 shows blank,blank,blank and then 0001111 on units; value=1000 shows 1,0,0,0 with no blanking.
REQ-029 Mid-conversion change: value=42 is sampled, then value becomes 99 on the 3rd SHIFT cycle.
  Response: the next conv_done shows 42; the conv_done after that shows 99.
REQ-030 Reset mid-operation: value=555, rst asserted on the 6th SHIFT cycle for 1 cycle.
  Response: no conv_done; the digits stay 0; the first conv_done is 15 cycles after release and shows 555.
REQ-031 Refresh wrap: the counter reaching all-ones SHALL wrap to 0, with sel going from 3 to 0 and Anode going from 1110 to 0111.
